// File: rtl/ifu_fetch.sv
// Instruction fetch: sequential ITCM fetch from the reset vector, in-order response queue, redirect.
// Optional IFU_MISALIGN_CHK_EN: a misaligned redirect/reset target produces one error entry and parks in ERR.
module ifu_fetch #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_rtvec,
    output logic            ifu2itcm_cmd_valid,
    input  logic            ifu2itcm_cmd_ready,
    output logic [AW-1:0]   ifu2itcm_cmd_addr,
    input  logic            ifu2itcm_rsp_valid,
    output logic            ifu2itcm_rsp_ready,
    input  logic [DW-1:0]   ifu2itcm_rsp_rdata,
    input  logic            flush_req,
    input  logic [PC_W-1:0] flush_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [DW-1:0]   ir_instr,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StBoot, StRun, StErr} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] held_pc_q, held_pc_d;
    logic            held_q, held_d;
    logic            stale_q, stale_d;
    logic            rsp_rdy_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   unfill_q, unfill_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PC_W-1:0] q_pc_q [DEPTH];
    logic [PC_W-1:0] q_pc_d [DEPTH];
    logic [DW-1:0]   q_instr_q [DEPTH];
    logic [DW-1:0]   q_instr_d [DEPTH];
    logic [DEPTH-1:0] q_filled_q, q_filled_d;
`ifdef IFU_MISALIGN_CHK_EN
    logic [DEPTH-1:0] q_err_q, q_err_d;
`endif

    logic [CW:0]     alloc_cnt;
    logic [PC_W-1:0] cmd_pc;
    logic [PC_W-1:0] tgt_pc;
    logic            tgt_bad;
    logic            redirect;
    logic            cmd_hs, cmd_stale, rsp_acc, ir_hs;
    logic            do_alloc, do_fill, do_consume;

    assign alloc_cnt = {1'b0, cnt_q} + {1'b0, drop_q};
    // A held command keeps its address even after fetch_pc is redirected.
    assign cmd_pc    = held_q ? held_pc_q : fetch_pc_q;
    assign ifu2itcm_cmd_valid = held_q | ((state_q == StRun) && (alloc_cnt < (CW+1)'(DEPTH)));
    assign ifu2itcm_cmd_addr  = cmd_pc[AW-1:0];
    assign ifu2itcm_rsp_ready = rsp_rdy_q;

    assign cmd_hs    = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;
    assign cmd_stale = held_q & stale_q;
    assign rsp_acc   = ifu2itcm_rsp_valid & rsp_rdy_q;
    assign ir_hs     = ir_valid & ir_ready;

    assign redirect = flush_req | (state_q == StBoot);
    assign tgt_pc   = flush_req ? flush_pc : pc_rtvec;
`ifdef IFU_MISALIGN_CHK_EN
    assign tgt_bad  = |tgt_pc[1:0];
    assign ir_err   = q_filled_q[rd_ptr_q] & q_err_q[rd_ptr_q];
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^tgt_pc[1:0];
    assign tgt_bad  = 1'b0;
    assign ir_err   = 1'b0;
`endif

    assign ir_valid = q_filled_q[rd_ptr_q];
    assign ir_instr = q_instr_q[rd_ptr_q];
    assign ir_pc    = q_pc_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        held_d     = ifu2itcm_cmd_valid & ~ifu2itcm_cmd_ready;
        held_pc_d  = cmd_pc;
        stale_d    = held_d & (flush_req | stale_q);
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        unfill_d   = unfill_q;
        drop_d     = drop_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        q_filled_d = q_filled_q;
`ifdef IFU_MISALIGN_CHK_EN
        q_err_d    = q_err_q;
`endif
        do_alloc   = 1'b0;
        do_fill    = 1'b0;
        do_consume = 1'b0;

        if (redirect) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            unfill_d   = '0;
            q_filled_d = '0;
            // Owed responses: unfilled entries, pending drops, this cycle's command, minus this cycle's response.
            if (flush_req) begin
                drop_d = unfill_q + drop_q + CW'(cmd_hs) - CW'(rsp_acc);
            end
            if (tgt_bad) begin
                q_pc_d[0]     = tgt_pc;
                q_instr_d[0]  = '0;
                q_filled_d[0] = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
                q_err_d[0]    = 1'b1;
`endif
                wr_ptr_d   = PW'(1);
                fill_ptr_d = PW'(1);
                cnt_d      = CW'(1);
                state_d    = StErr;
            end else begin
                fetch_pc_d = {tgt_pc[PC_W-1:2], 2'b00};
                state_d    = StRun;
            end
        end else begin
            do_alloc   = cmd_hs & ~cmd_stale;
            do_fill    = rsp_acc & (drop_q == '0);
            do_consume = ir_hs;
            drop_d     = drop_q + CW'(cmd_hs & cmd_stale) - CW'(rsp_acc & (drop_q != '0));

            if (do_alloc) begin
                q_pc_d[wr_ptr_q] = cmd_pc;
`ifdef IFU_MISALIGN_CHK_EN
                q_err_d[wr_ptr_q] = 1'b0;
`endif
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (do_fill) begin
                q_instr_d[fill_ptr_q]  = ifu2itcm_rsp_rdata;
                q_filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d = fill_ptr_q + PW'(1);
            end
            if (do_consume) begin
                q_filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d    = cnt_q + CW'(do_alloc) - CW'(do_consume);
            unfill_d = unfill_q + CW'(do_alloc) - CW'(do_fill);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            fetch_pc_q <= '0;
            held_pc_q  <= '0;
            held_q     <= 1'b0;
            stale_q    <= 1'b0;
            rsp_rdy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            unfill_q   <= '0;
            drop_q     <= '0;
            q_pc_q     <= '{default: '0};
            q_instr_q  <= '{default: '0};
            q_filled_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            q_err_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            held_pc_q  <= held_pc_d;
            held_q     <= held_d;
            stale_q    <= stale_d;
            rsp_rdy_q  <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            unfill_q   <= unfill_d;
            drop_q     <= drop_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
            q_filled_q <= q_filled_d;
`ifdef IFU_MISALIGN_CHK_EN
            q_err_q    <= q_err_d;
`endif
        end
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage in front of the ITCM controller. It generates sequential fetch addresses from the reset vector, issues them over the ifu2itcm command/response handshake, and buffers returned instructions with their PCs in an in-order queue. It drives a valid/ready instruction port to decode and supports a single-cycle redirect (flush) from execute.

## Interface
- PC_W, 32, PC width (matches `PC_SIZE`)
- AW, 16, ITCM byte-address width (matches `ITCM_ADDR_WIDTH`)
- DW, 32, instruction width (matches `ITCM_RAM_DW`)
- DEPTH, 4, instruction queue entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- pc_rtvec  in  PC_W  reset vector; sampled in the first cycle after reset release
- ifu2itcm_cmd_valid  out  1  fetch command valid
- ifu2itcm_cmd_ready  in  1  ITCM accepts command
- ifu2itcm_cmd_addr  out  AW  fetch byte address, equal to fetch_pc[AW-1:0]
- ifu2itcm_rsp_valid  in  1  instruction word returned
- ifu2itcm_rsp_ready  out  1  always 1 after reset; space is pre-reserved
- ifu2itcm_rsp_rdata  in  DW  instruction word
- flush_req  in  1  one-cycle redirect pulse
- flush_pc  in  PC_W  redirect target
- ir_valid  out  1  instruction available to decode
- ir_ready  in  1  decode accepts
- ir_instr  out  DW  instruction
- ir_pc  out  PC_W  PC of ir_instr
- ir_err  out  1  misaligned-fetch marker (see Configuration)

## Operation
- States: BOOT (one cycle after reset, fetch_pc ← {pc_rtvec[PC_W-1:2],2'b00}), RUN, ERR.
- Queue: DEPTH entries {pc, instr, filled}; wr_ptr allocates at command handshake (stores pc), fill_ptr writes instr and sets filled on an accepted, non-dropped response, rd_ptr advances on ir_valid & ir_ready. ir_valid = entry[rd_ptr].filled.
- Issue: cmd_valid in RUN when alloc_cnt < DEPTH, where alloc_cnt = allocated entries + drop_cnt. On handshake fetch_pc ← fetch_pc + 4, wrapping modulo 2^PC_W.
- Once asserted, cmd_valid and cmd_addr hold until cmd_ready; a flush does not withdraw a held command.
- Flush (wins over every simultaneous event): all queue entries are discarded, pointers are reset, fetch_pc ← flush_pc (low two bits cleared), and the state goes to RUN. drop_cnt ← responses still owed, including a command handshaked in the flush cycle and a held, unaccepted command (counted when it is later accepted). It excludes any response arriving in the flush cycle, which is dropped directly.
- While drop_cnt > 0, each response decrements drop_cnt and is not written.
- A flush in BOOT is applied; pc_rtvec is then ignored.
- Responses return in command order; no reordering.

## Timing
- Reset values: cmd_valid=0, cmd_addr=0, rsp_ready=0, ir_valid=0, ir_instr=0, ir_pc=0, ir_err=0, drop_cnt=0. Asserting rst_n=0 mid-operation clears the queue immediately.
- rst_n released before edge E0: BOOT at E0, cmd_valid=1 with pc_rtvec from E1.
- flush_req at edge N with no held command: cmd_valid=1, cmd_addr=flush_pc from N+1.
- Fetch-to-decode: command accepted at edge C, 1-cycle ITCM response at C+1, ir_valid=1 at C+2.
- With 1-cycle ITCM latency, DEPTH=4, and ir_ready=1, throughput is 1 instruction per cycle.
- No combinational path from ir_ready to cmd_valid, or from cmd_ready to ir_valid.

## Configuration
- `IFU_MISALIGN_CHK_EN` defined: if flush_pc[1:0] or pc_rtvec[1:0] is nonzero, no command is issued. One entry is enqueued with ir_err=1, ir_pc=the unmodified target, and ir_instr=0, and the state goes to ERR. ERR issues nothing until the next flush.
- Not defined: the low two bits are silently cleared, ERR is unreachable, and ir_err is tied to 0.

## Test plan
- Reset: pc_rtvec=0x8000_0000, ITCM ready with 1-cycle latency, ir_ready=1 -> cmd_addr sequence 0x0000, 0x0004, 0x0008…; ir_pc 0x8000_0000, 0x8000_0004… back-to-back, one per cycle.
- Backpressure: ir_ready=0 for 10 cycles -> exactly 4 commands issued, then cmd_valid=0. Release ir_ready -> order is preserved, with no loss or duplicate.
- Flush with two responses in flight, flush_pc=0x8000_0100 -> both stale responses are dropped and the next ir_pc is 0x8000_0100. With the ITCM returning 1 per cycle, ir_valid is high 3 cycles after the flush.
- Flush while cmd_valid is held with cmd_ready=0 at addr 0x0010 -> addr 0x0010 stays stable until accepted, its response is dropped, and the next command is flush_pc.
- PC wrap: flush_pc=0xFFFF_FFFC -> ir_pc 0xFFFF_FFFC, then 0x0000_0000.
- With IFU_MISALIGN_CHK_EN: flush_pc=0x8000_0002 -> no command, one ir with ir_err=1 and ir_pc=0x8000_0002, then idle until a flush to 0x8000_0000 resumes normal fetch.
